// File: rtl/hazard_ctrl_unit.sv
// Sequential pipeline hazard controller for the 5-stage RISC-V core.
// Handles multi-cycle load-use stalls, data-memory wait freezes and
// taken-branch flushes. All outputs respond combinationally in the same cycle.
// Optional feature macro: HAZARD_PERF_CNT_EN adds saturating stall, flush
// and freeze event counters on extra output ports.
module hazard_ctrl_unit #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] ID_Rs1_i,
    input  logic [REG_AW-1:0] ID_Rs2_i,
    input  logic              ID_Rs1Use_i,
    input  logic              ID_Rs2Use_i,
    input  logic [REG_AW-1:0] EX_Rd_i,
    input  logic              EX_MemRead_i,
    input  logic              EX_BranchTaken_i,
    input  logic              MEM_Req_i,
    input  logic              MEM_Ready_i,
    output logic              PC_Write_o,
    output logic              Stall_o,
    output logic              NoOp_o,
    output logic              Flush_o,
    output logic              Freeze_o,
    output logic              Busy_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o,
    output logic [CNT_W-1:0]  freeze_cnt_o
`endif
);

    localparam int CW = $clog2(LOAD_LAT) + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    // Reject illegal parameterisations at elaboration time.
    if (LOAD_LAT < 1 || LOAD_LAT > 7) begin : g_bad_load_lat
        $error("hazard_ctrl_unit: LOAD_LAT must be in 1..7");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("hazard_ctrl_unit: CNT_W must be at least 1");
    end

    state_t          state, state_nxt;
    state_t          ret_state, ret_nxt;
    state_t          eff_state;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            lu_hit;
    logic            mem_wait;
    logic            stall_now;

    assign lu_hit = EX_MemRead_i && (EX_Rd_i != '0) &&
                    ((ID_Rs1Use_i && (EX_Rd_i == ID_Rs1_i)) ||
                     (ID_Rs2Use_i && (EX_Rd_i == ID_Rs2_i)));

    assign mem_wait = MEM_Req_i && !MEM_Ready_i;

    // While frozen, behave as the state we will return to once memory is ready.
    assign eff_state = (state == MEM_WAIT) ? ret_state : state;

    // State, return-state and stall counter registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state     <= IDLE;
            ret_state <= IDLE;
            cnt       <= '0;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_nxt;
            cnt       <= cnt_nxt;
        end
    end

    // Next-state logic; a freeze holds cnt and remembers where to resume.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_nxt = state;
        ret_nxt   = ret_state;
        cnt_nxt   = cnt;
        if (mem_wait) begin
            if (state != MEM_WAIT) begin
                ret_nxt   = state;
                state_nxt = MEM_WAIT;
            end
        end else begin
            case (eff_state)
                LU_STALL: begin
                    if (EX_BranchTaken_i || (cnt == CW'(1))) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = LU_STALL;
                        cnt_nxt   = cnt - 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    if (!EX_BranchTaken_i && lu_hit && (LOAD_LAT > 1)) begin
                        state_nxt = LU_STALL;
                        cnt_nxt   = CW'(LOAD_LAT - 1);
                    end
                end
            endcase
        end
    end

    // Output equations with priority freeze > flush > load-use stall.
    always_comb begin
        PC_Write_o = 1'b1;
        Stall_o    = 1'b0;
        NoOp_o     = 1'b0;
        Flush_o    = 1'b0;
        Freeze_o   = 1'b0;
        stall_now  = ((eff_state == IDLE) && lu_hit) || (eff_state == LU_STALL);
        if (mem_wait) begin
            Freeze_o   = 1'b1;
            Stall_o    = 1'b1;
            PC_Write_o = 1'b0;
        end else if (EX_BranchTaken_i) begin
            Flush_o    = 1'b1;
            NoOp_o     = 1'b1;
        end else if (stall_now) begin
            Stall_o    = 1'b1;
            NoOp_o     = 1'b1;
            PC_Write_o = 1'b0;
        end
    end

    assign Busy_o = (state != IDLE);

`ifdef HAZARD_PERF_CNT_EN
    // Saturating event counters for stall, flush and freeze cycles.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o  <= '0;
            flush_cnt_o  <= '0;
            freeze_cnt_o <= '0;
        end else begin
            if (Stall_o && !Freeze_o && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
            if (Flush_o && (flush_cnt_o != '1)) begin
                flush_cnt_o <= flush_cnt_o + 1'b1;
            end
            if (Freeze_o && (freeze_cnt_o != '1)) begin
                freeze_cnt_o <= freeze_cnt_o + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit. Two instances (LOAD_LAT=1 and
// LOAD_LAT=3) share one stimulus. A table of single-cycle vectors checks the
// idle-state equations, hand sequences cover multi-cycle stall/freeze/flush
// and async reset, and a random phase compares against a cycle-count model.
// Counter checks are compiled in when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_ctrl_unit;

    localparam int AW = 5;
    localparam int CW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [AW-1:0] id_rs1, id_rs2, ex_rd;
    logic          rs1_use, rs2_use, mem_read, taken, mem_req, mem_ready;

    logic pcw[2], stall[2], noop[2], flush[2], freeze[2], busy[2];
`ifdef HAZARD_PERF_CNT_EN
    logic [CW-1:0] stall_cnt[2], flush_cnt[2], freeze_cnt[2];
`endif

    always #5 clk_i = ~clk_i;

    hazard_ctrl_unit #(.REG_AW(AW), .LOAD_LAT(1), .CNT_W(CW)) u_lat1 (
        .clk_i(clk_i), .rst_i(rst_i),
        .ID_Rs1_i(id_rs1), .ID_Rs2_i(id_rs2),
        .ID_Rs1Use_i(rs1_use), .ID_Rs2Use_i(rs2_use),
        .EX_Rd_i(ex_rd), .EX_MemRead_i(mem_read), .EX_BranchTaken_i(taken),
        .MEM_Req_i(mem_req), .MEM_Ready_i(mem_ready),
        .PC_Write_o(pcw[0]), .Stall_o(stall[0]), .NoOp_o(noop[0]),
        .Flush_o(flush[0]), .Freeze_o(freeze[0]), .Busy_o(busy[0])
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt_o(stall_cnt[0]), .flush_cnt_o(flush_cnt[0]),
        .freeze_cnt_o(freeze_cnt[0])
`endif
    );

    hazard_ctrl_unit #(.REG_AW(AW), .LOAD_LAT(3), .CNT_W(CW)) u_lat3 (
        .clk_i(clk_i), .rst_i(rst_i),
        .ID_Rs1_i(id_rs1), .ID_Rs2_i(id_rs2),
        .ID_Rs1Use_i(rs1_use), .ID_Rs2Use_i(rs2_use),
        .EX_Rd_i(ex_rd), .EX_MemRead_i(mem_read), .EX_BranchTaken_i(taken),
        .MEM_Req_i(mem_req), .MEM_Ready_i(mem_ready),
        .PC_Write_o(pcw[1]), .Stall_o(stall[1]), .NoOp_o(noop[1]),
        .Flush_o(flush[1]), .Freeze_o(freeze[1]), .Busy_o(busy[1])
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt_o(stall_cnt[1]), .flush_cnt_o(flush_cnt[1]),
        .freeze_cnt_o(freeze_cnt[1])
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    // Output bundle order: {PC_Write, Stall, NoOp, Flush, Freeze, Busy}
    typedef struct {
        string         name;
        logic [AW-1:0] rs1, rs2, rd;
        logic          u1, u2, mr, tk, rq, rdy;
        logic [5:0]    exp;
    } vec_t;

    // Reference model: remaining forced stall cycles plus a "was waiting" flag.
    int lat[2];
    int m_left[2];
    bit m_wait[2];
    int m_stall_cnt[2], m_flush_cnt[2], m_freeze_cnt[2];

    function automatic logic [5:0] dut_out(input int i);
        return {pcw[i], stall[i], noop[i], flush[i], freeze[i], busy[i]};
    endfunction

    function automatic bit cur_lu_hit();
        return mem_read && (ex_rd != 0) &&
               ((rs1_use && ex_rd == id_rs1) || (rs2_use && ex_rd == id_rs2));
    endfunction

    function automatic logic [5:0] model_out(input int i);
        bit mw = mem_req && !mem_ready;
        bit b  = (m_left[i] > 0) || m_wait[i];
        if (mw)                           return {5'b01001, b};
        if (taken)                        return {5'b10110, b};
        if (m_left[i] > 0 || cur_lu_hit()) return {5'b01100, b};
        return {5'b10000, b};
    endfunction

    task automatic model_step(input int i);
        logic [5:0] o = model_out(i);
        bit mw = mem_req && !mem_ready;
        if (o[4] && !o[1]) m_stall_cnt[i]++;
        if (o[2])          m_flush_cnt[i]++;
        if (o[1])          m_freeze_cnt[i]++;
        if (mw) begin
            m_wait[i] = 1'b1;
        end else begin
            m_wait[i] = 1'b0;
            if (taken)              m_left[i] = 0;
            else if (m_left[i] > 0) m_left[i]--;
            else if (cur_lu_hit())  m_left[i] = lat[i] - 1;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_left[i] = 0; m_wait[i] = 1'b0;
            m_stall_cnt[i] = 0; m_flush_cnt[i] = 0; m_freeze_cnt[i] = 0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                          input logic [AW-1:0] rd, input logic u1, input logic u2,
                          input logic mr, input logic tk, input logic rq, input logic rdy);
        id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
        rs1_use = u1; rs2_use = u2; mem_read = mr;
        taken = tk; mem_req = rq; mem_ready = rdy;
    endtask

    task automatic quiet();
        set_in('0, '0, '0, 0, 0, 0, 0, 0, 0);
    endtask

    // Called just after an active edge; reset pulse completes before the next edge.
    task automatic do_reset();
        #1 rst_i = 1'b0;
        #2 model_reset();
        rst_i = 1'b1;
    endtask

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk_i);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        lat[0] = 1; lat[1] = 3;
        rst_i = 1'b0;
        quiet();
        model_reset();
        #12 rst_i = 1'b1;

        // ---- Idle-state combinational vectors (both instances) ----
        vecs.push_back('{"quiet",        0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b100000});
        vecs.push_back('{"lu_rs1",       5, 0, 5, 1, 0, 1, 0, 0, 0, 6'b011000});
        vecs.push_back('{"lu_rs1_nouse", 5, 0, 5, 0, 0, 1, 0, 0, 0, 6'b100000});
        vecs.push_back('{"lu_rd0",       0, 0, 0, 1, 1, 1, 0, 0, 0, 6'b100000});
        vecs.push_back('{"lu_rs2",       1, 7, 7, 1, 1, 1, 0, 0, 0, 6'b011000});
        vecs.push_back('{"lu_rs2_nouse", 1, 7, 7, 1, 0, 1, 0, 0, 0, 6'b100000});
        vecs.push_back('{"no_load",      5, 5, 5, 1, 1, 0, 0, 0, 0, 6'b100000});
        vecs.push_back('{"taken_lu",     5, 0, 5, 1, 0, 1, 1, 0, 0, 6'b101100});
        vecs.push_back('{"mem_wait",     0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b010010});
        vecs.push_back('{"wait_tk_lu",   5, 0, 5, 1, 0, 1, 1, 1, 0, 6'b010010});
        vecs.push_back('{"req_ready_lu", 5, 0, 5, 1, 0, 1, 0, 1, 1, 6'b011000});
        vecs.push_back('{"ready_noreq",  0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b100000});
        foreach (vecs[k]) begin
            @(posedge clk_i); #1;
            do_reset();
            set_in(vecs[k].rs1, vecs[k].rs2, vecs[k].rd, vecs[k].u1, vecs[k].u2,
                   vecs[k].mr, vecs[k].tk, vecs[k].rq, vecs[k].rdy);
            #1;
            check({vecs[k].name, "_lat1"}, 32'(dut_out(0)), 32'(vecs[k].exp));
            check({vecs[k].name, "_lat3"}, 32'(dut_out(1)), 32'(vecs[k].exp));
        end
        quiet();
        @(posedge clk_i); #1;

        // ---- LOAD_LAT=1: one bubble, then EX holds the bubble ----
        do_reset();
        set_in(5, 0, 5, 1, 0, 1, 0, 0, 0); #1;
        check("lat1_bubble", 32'(dut_out(0)), 32'(6'b011000));
        tick();
        set_in(5, 0, 0, 1, 0, 0, 0, 0, 0); #1;
        check("lat1_after", 32'(dut_out(0)), 32'(6'b100000));
        tick();

        // ---- LOAD_LAT=3: rs2 hit stalls three cycles ----
        do_reset();
        set_in(1, 7, 7, 1, 1, 1, 0, 0, 0); #1;
        check("lat3_c1", 32'(dut_out(1)), 32'(6'b011000));
        tick();
        set_in(1, 7, 0, 1, 1, 0, 0, 0, 0); #1;
        check("lat3_c2", 32'(dut_out(1)), 32'(6'b011001));
        tick(); #1;
        check("lat3_c3", 32'(dut_out(1)), 32'(6'b011001));
        tick(); #1;
        check("lat3_c4", 32'(dut_out(1)), 32'(6'b100000));

        // ---- LOAD_LAT=3: four-cycle freeze inside the stall ----
        do_reset();
        set_in(1, 7, 7, 1, 1, 1, 0, 0, 0); #1;
        check("frz_c1", 32'(dut_out(1)), 32'(6'b011000));
        tick();
        set_in(1, 7, 0, 1, 1, 0, 0, 1, 0); #1;
        for (int c = 0; c < 4; c++) begin
            check("frz_wait", 32'(dut_out(1)), 32'(6'b010011));
            tick();
            if (c == 3) mem_req = 1'b0;
            #1;
        end
        check("frz_resume1", 32'(dut_out(1)), 32'(6'b011001));
        tick(); #1;
        check("frz_resume2", 32'(dut_out(1)), 32'(6'b011001));
        tick(); #1;
        check("frz_done", 32'(dut_out(1)), 32'(6'b100000));

        // ---- Taken branch aborts LU_STALL ----
        do_reset();
        set_in(1, 7, 7, 1, 1, 1, 0, 0, 0); #1;
        tick();
        set_in(1, 7, 0, 1, 1, 0, 1, 0, 0); #1;
        check("abort_flush", 32'(dut_out(1)), 32'(6'b101101));
        tick();
        taken = 1'b0; #1;
        check("abort_idle", 32'(dut_out(1)), 32'(6'b100000));

        // ---- Simultaneous wait and taken: freeze first, flush after ----
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 1, 1, 0); #1;
        check("wt_freeze0", 32'(dut_out(1)), 32'(6'b010010));
        tick(); #1;
        check("wt_freeze1", 32'(dut_out(1)), 32'(6'b010011));
        tick();
        mem_req = 1'b0; #1;
        check("wt_flush", 32'(dut_out(1)), 32'(6'b101101));
        tick();
        taken = 1'b0; #1;
        check("wt_idle", 32'(dut_out(1)), 32'(6'b100000));

        // ---- Async reset mid-stall ----
        do_reset();
        set_in(1, 7, 7, 1, 1, 1, 0, 0, 0); #1;
        tick();
        set_in(1, 7, 0, 1, 1, 0, 0, 0, 0); #1;
        check("rst_pre_busy", 32'(busy[1]), 32'd1);
        rst_i = 1'b0; #1;
        check("rst_mid_out", 32'(dut_out(1)), 32'(6'b100000));
`ifdef HAZARD_PERF_CNT_EN
        check("rst_stall_cnt", stall_cnt[1], 32'd0);
        check("rst_flush_cnt", flush_cnt[1], 32'd0);
        check("rst_freeze_cnt", freeze_cnt[1], 32'd0);
`endif
        model_reset();
        rst_i = 1'b1;
        quiet();
        tick();

        // ---- Random stimulus against the reference model ----
        do_reset();
        for (int n = 0; n < 600; n++) begin
            set_in(AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
                   AW'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
            #1;
            for (int i = 0; i < 2; i++) begin
                check(i == 0 ? "rand_lat1" : "rand_lat3",
                      32'(dut_out(i)), 32'(model_out(i)));
`ifdef HAZARD_PERF_CNT_EN
                check("rand_stall_cnt", stall_cnt[i], 32'(m_stall_cnt[i]));
                check("rand_flush_cnt", flush_cnt[i], 32'(m_flush_cnt[i]));
                check("rand_freeze_cnt", freeze_cnt[i], 32'(m_freeze_cnt[i]));
`endif
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Parametrised pipeline hazard controller for the 5-stage RISC-V core. It replaces the purely combinational single-bubble load-use detector with a sequential controller. It generates PC/IF-ID hold, ID/EX bubble insertion, IF-ID flush and whole-pipe freeze. It handles:
- configurable multi-cycle load-use latency
- data-memory wait handshake
- taken-branch flush
- per-operand use qualification

Parameters:
REG_AW, 5, register-index width.
LOAD_LAT, 1, load-use bubble count (legal 1..7).
CNT_W, 32, perf-counter width (used only with HAZARD_PERF_CNT_EN).

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  reset, asynchronous, active-low.
ID_Rs1_i  in  REG_AW  ID-stage source register 1.
ID_Rs2_i  in  REG_AW  ID-stage source register 2.
ID_Rs1Use_i  in  1  ID instruction actually reads rs1.
ID_Rs2Use_i  in  1  ID instruction actually reads rs2.
EX_Rd_i  in  REG_AW  EX-stage destination register.
EX_MemRead_i  in  1  EX-stage instruction is a load.
EX_BranchTaken_i  in  1  EX-stage branch/jump resolved taken.
MEM_Req_i  in  1  MEM stage has an outstanding data-memory access.
MEM_Ready_i  in  1  data memory completes access this cycle.
PC_Write_o  out  1  PC update enable.
Stall_o  out  1  IF/ID hold.
NoOp_o  out  1  insert bubble into ID/EX.
Flush_o  out  1  clear IF/ID.
Freeze_o  out  1  hold all pipeline registers (IF/ID through MEM/WB).
Busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst_i=0, async): FSM=IDLE, cnt=0. Outputs follow the IDLE combinational equations, so a quiet pipe gives PC_Write_o=1 and all others 0.
- Definitions:
  - lu_hit = EX_MemRead_i & EX_Rd_i!=0 & ((ID_Rs1Use_i & EX_Rd_i==ID_Rs1_i) | (ID_Rs2Use_i & EX_Rd_i==ID_Rs2_i)).
  - mem_wait = MEM_Req_i & ~MEM_Ready_i.
- Outputs are combinational from state and inputs, with zero-cycle response. Priority: freeze > flush > load-use.
  - mem_wait=1: Freeze_o=1, Stall_o=1, PC_Write_o=0, NoOp_o=0, Flush_o=0.
  - else EX_BranchTaken_i=1: Flush_o=1, NoOp_o=1, Stall_o=0, PC_Write_o=1 (redirect).
  - else stall_now = (IDLE & lu_hit) | LU_STALL. If stall_now: Stall_o=1, NoOp_o=1, PC_Write_o=0.
  - else: PC_Write_o=1, all others 0.
- FSM states:
  - IDLE
  - LU_STALL: counter cnt, width clog2(LOAD_LAT)+1
  - MEM_WAIT
- Transitions from IDLE:
  - mem_wait -> MEM_WAIT; save return=IDLE.
  - else taken -> IDLE.
  - else lu_hit & LOAD_LAT>1 -> LU_STALL, cnt=LOAD_LAT-1.
  - else stay in IDLE.
- LOAD_LAT=1 is exactly one bubble and the FSM never leaves IDLE.
- Transitions from LU_STALL:
  - mem_wait -> MEM_WAIT; save return=LU_STALL, cnt unchanged.
  - else taken -> IDLE, stall aborted.
  - else cnt==1 -> IDLE.
  - else cnt-1.
- Total load-use stall = LOAD_LAT cycles, excluding freeze cycles.
- Transitions from MEM_WAIT:
  - Stay while mem_wait.
  - When it clears, return to the saved state in the same cycle; outputs that cycle use the returned state's equations.
- Freeze never decrements cnt.
- Hazard detection is not re-evaluated during LU_STALL. The ID instruction is held, so on return to IDLE lu_hit is naturally false once the load has left EX.
- Busy_o=1 in LU_STALL or MEM_WAIT.
- rs==0 never hazards (guarded via EX_Rd_i!=0).
- Simultaneous mem_wait and taken: freeze only; the flush is taken on the first non-wait cycle, because EX is held.

Optional Feature:
HAZARD_PERF_CNT_EN.
- Defined: adds output ports stall_cnt_o [CNT_W], flush_cnt_o [CNT_W] and freeze_cnt_o [CNT_W].
  - Each counter increments by 1 per cycle in which Stall_o&~Freeze_o, Flush_o or Freeze_o respectively is high.
  - Counters saturate at all-ones and clear on reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- LOAD_LAT=1, EX load rd=5, ID rs1=5 with Use=1 -> one cycle of Stall_o=NoOp_o=1, PC_Write_o=0, Busy_o=0; next cycle (EX bubble) all clear.
- Same as above but ID_Rs1Use_i=0 or EX_Rd_i=0 -> no stall.
- LOAD_LAT=3, rd=7 matches rs2 -> stall for exactly 3 cycles, Busy_o=1 on cycles 2-3, then PC_Write_o=1.
- LOAD_LAT=3: mem_wait raised on stall cycle 2 for 4 cycles -> Freeze_o=1 and NoOp_o=0 for 4 cycles, then 2 remaining stall cycles (total 7 held cycles).
- EX_BranchTaken_i=1 together with lu_hit -> Flush_o=1, NoOp_o=1, PC_Write_o=1, no stall. Taken during LU_STALL -> return to IDLE next cycle.
- Assert rst_i=0 mid-LU_STALL (async, between edges) -> outputs immediately return to IDLE equations, Busy_o=0. With HAZARD_PERF_CNT_EN, counters read 0.
